// File: rtl/cordic_driver.sv
// Host-side initiator for the CORDIC core.
// Takes one operand set per cmd handshake, drives the core operand bus plus a
// single-cycle core_start, waits for core_done and offers the captured X/Y on
// a valid/ready result port. One operation in flight at a time.
// Optional build macro: CORDIC_DRV_TIMEOUT_EN enables the WAIT-state watchdog
// (TIMEOUT_CYCLES) and the sticky err_timeout flag cleared by err_clr.
module cordic_driver #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic             Clk,
   input  logic             Reset,
   // command port
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_x,
   input  logic [WIDTH-1:0] cmd_y,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   // core side
   output logic             core_start,
   output logic [WIDTH-1:0] core_x,
   output logic [WIDTH-1:0] core_y,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_X,
   input  logic [WIDTH-1:0] core_Y,
   // result port
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_x,
   output logic [WIDTH-1:0] res_y,
   // status
   output logic             busy,
   output logic             err_timeout,
   input  logic             err_clr
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             core_start_d;
   logic [WIDTH-1:0] core_x_d, core_y_d, core_a_d, core_b_d;
   logic             res_valid_d;
   logic [WIDTH-1:0] res_x_d, res_y_d;

`ifdef CORDIC_DRV_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_d;
`else
   logic             unused_ok;
`endif

   // Handshake/status views of the state register
   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);

   // Next-state and next-register-value logic
   always_comb begin
      state_d      = state_q;
      core_start_d = 1'b0;
      core_x_d     = core_x;
      core_y_d     = core_y;
      core_a_d     = core_a;
      core_b_d     = core_b;
      res_valid_d  = res_valid;
      res_x_d      = res_x;
      res_y_d      = res_y;
`ifdef CORDIC_DRV_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_clr ? 1'b0 : err_timeout;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               core_x_d     = cmd_x;
               core_y_d     = cmd_y;
               core_a_d     = cmd_a;
               core_b_d     = cmd_b;
               core_start_d = 1'b1;
               state_d      = ST_ISSUE;
            end
         end

         // core_done seen here belongs to an earlier operation; ignore it
         ST_ISSUE: begin
`ifdef CORDIC_DRV_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (core_done) begin
               res_x_d     = core_X;
               res_y_d     = core_Y;
               res_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
`ifdef CORDIC_DRV_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // final WAIT cycle without a result: abort with a zero result
               err_d       = 1'b1;
               res_x_d     = '0;
               res_y_d     = '0;
               res_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end

         // result held stable; further core_done pulses do not overwrite it
         ST_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         core_start <= 1'b0;
         core_x     <= '0;
         core_y     <= '0;
         core_a     <= '0;
         core_b     <= '0;
         res_valid  <= 1'b0;
         res_x      <= '0;
         res_y      <= '0;
      end else begin
         state_q    <= state_d;
         core_start <= core_start_d;
         core_x     <= core_x_d;
         core_y     <= core_y_d;
         core_a     <= core_a_d;
         core_b     <= core_b_d;
         res_valid  <= res_valid_d;
         res_x      <= res_x_d;
         res_y      <= res_y_d;
      end
   end

`ifdef CORDIC_DRV_TIMEOUT_EN
   // Watchdog counter and sticky timeout flag
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q       <= '0;
         err_timeout <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         err_timeout <= err_d;
      end
   end
`else
   // Watchdog absent: flag tied low, clear input and counter sizing unused
   assign err_timeout = 1'b0;
   assign unused_ok   = &{1'b0, err_clr, CNT_W'(0)};
`endif

endmodule
